// File: rtl/karatsuba_mul_pipe.sv
// rtl/karatsuba_mul_pipe.sv - 3-stage pipelined Karatsuba multiplier with signed mode, valid/ready and tag
// One top-level split: magnitudes are multiplied as three half-width products, sign applied at the end.
module karatsuba_mul_pipe #(
  parameter int W     = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag
);
  localparam int H = W / 2;
  localparam logic [W-1:0]   ONE_W  = 1;
  localparam logic [2*W-1:0] ONE_2W = 1;

  logic adv;

  logic             v1_q, sign1_q;
  logic [H-1:0]     a0_q, a1_q, b0_q, b1_q;
  logic [H:0]       sa_q, sb_q;
  logic [TAG_W-1:0] tag1_q;

  logic             v2_q, sign2_q;
  logic [W-1:0]     p0_q, p2_q;
  logic [W+1:0]     pm_q;
  logic [TAG_W-1:0] tag2_q;

  logic             v3_q;
  logic [2*W-1:0]   out_p_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             neg_a, neg_b;
  logic [W-1:0]     mag_a, mag_b;
  logic             sign1_d;
  logic [H-1:0]     a0_d, a1_d, b0_d, b1_d;
  logic [H:0]       sa_d, sb_d;
  logic [W-1:0]     p0_d, p2_d;
  logic [W+1:0]     pm_d;
  logic [W+1:0]     mid;
  logic [2*W-1:0]   u;
  logic [2*W-1:0]   out_p_d;

  // Stage 1: magnitudes (the most negative value maps cleanly to 2^(W-1)) and half sums
  always_comb begin
    neg_a   = in_signed & in_a[W-1];
    neg_b   = in_signed & in_b[W-1];
    mag_a   = neg_a ? (~in_a + ONE_W) : in_a;
    mag_b   = neg_b ? (~in_b + ONE_W) : in_b;
    sign1_d = in_signed & (in_a[W-1] ^ in_b[W-1]);
    a0_d    = mag_a[H-1:0];
    a1_d    = mag_a[W-1:H];
    b0_d    = mag_b[H-1:0];
    b1_d    = mag_b[W-1:H];
    sa_d    = {1'b0, a0_d} + {1'b0, a1_d};
    sb_d    = {1'b0, b0_d} + {1'b0, b1_d};
  end

  always_comb begin
    p0_d = {{H{1'b0}}, a0_q} * {{H{1'b0}}, b0_q};
    p2_d = {{H{1'b0}}, a1_q} * {{H{1'b0}}, b1_q};
    pm_d = {{(H+1){1'b0}}, sa_q} * {{(H+1){1'b0}}, sb_q};
  end

  // Stage 3: recombine; mid never goes negative so the subtraction needs no sign handling
  always_comb begin
    mid     = pm_q - {2'b00, p0_q} - {2'b00, p2_q};
    u       = {p2_q, {W{1'b0}}} + ({{(W-2){1'b0}}, mid} << H) + {{W{1'b0}}, p0_q};
    out_p_d = sign2_q ? (~u + ONE_2W) : u;
  end

  assign adv       = ~v3_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_p     = out_p_q;
  assign out_tag   = out_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      sign1_q   <= 1'b0;
      a0_q      <= '0;
      a1_q      <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      sa_q      <= '0;
      sb_q      <= '0;
      tag1_q    <= '0;
      v2_q      <= 1'b0;
      sign2_q   <= 1'b0;
      p0_q      <= '0;
      p2_q      <= '0;
      pm_q      <= '0;
      tag2_q    <= '0;
      v3_q      <= 1'b0;
      out_p_q   <= '0;
      out_tag_q <= '0;
    end else if (adv) begin
      v1_q      <= in_valid;
      sign1_q   <= sign1_d;
      a0_q      <= a0_d;
      a1_q      <= a1_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      tag1_q    <= in_tag;
      v2_q      <= v1_q;
      sign2_q   <= sign1_q;
      p0_q      <= p0_d;
      p2_q      <= p2_d;
      pm_q      <= pm_d;
      tag2_q    <= tag1_q;
      v3_q      <= v2_q;
      out_p_q   <= out_p_d;
      out_tag_q <= tag2_q;
    end
  end

endmodule
